// File: rtl/junction_pkg.sv
// ---------------------------------------------------------------------------
// junction_pkg
//   Shared types and constants for the junction turn sequencer.
//   - jctState_t : sequencer states
//   - jctDir_t   : tone direction codes as delivered on tdDir
//   - HB_*       : H-bridge direction patterns, packed as {In1,In2,In3,In4}
//   - inPattern  : direction code -> H-bridge direction pattern
//   - timerWidth : bits needed to count 0 .. maxCycles-1 (never less than 1)
// ---------------------------------------------------------------------------
package junction_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_TONE = 3'd1,
      SETTLE    = 3'd2,
      EXECUTE   = 3'd3,
      PAUSE     = 3'd4,
      DONE      = 3'd5,
      FAULT     = 3'd6
   } jctState_t;

   typedef enum logic [1:0] {
      STRAIGHT = 2'b00,
      LEFT     = 2'b01,
      RIGHT    = 2'b10,
      BACK     = 2'b11
   } jctDir_t;

   // {In1,In2,In3,In4}
   localparam logic [3:0] HB_FWD    = 4'b0110;
   localparam logic [3:0] HB_SPIN_L = 4'b1010;
   localparam logic [3:0] HB_SPIN_R = 4'b0101;

   localparam int PULSE_CNT_W = 8;

   // A U-turn is a long right spin, so BACK shares the SPIN_R pattern.
   function automatic logic [3:0] inPattern(input jctDir_t dir);
      logic [3:0] pat;
      unique case (dir)
         STRAIGHT: pat = HB_FWD;
         LEFT:     pat = HB_SPIN_L;
         RIGHT:    pat = HB_SPIN_R;
         BACK:     pat = HB_SPIN_R;
         default:  pat = HB_FWD;
      endcase
      return pat;
   endfunction

   function automatic int timerWidth(input int maxCycles);
      return (maxCycles > 1) ? $clog2(maxCycles) : 1;
   endfunction

endpackage

// File: rtl/shaft_pulse_sync.sv
// ---------------------------------------------------------------------------
// shaft_pulse_sync
//   Brings one asynchronous shaft-encoder line into the clk domain through a
//   two-flop synchronizer and emits a one-cycle pulse on each rising edge.
//   The pulse is combinational from the synchronizer flops, so a counter
//   clocked by the same clk registers the edge on the third clock edge after
//   the input rises.
//
//   Ports:
//     clk      in   system clock
//     rst      in   synchronous, active-high reset
//     shaftIn  in   raw encoder line, asynchronous to clk
//     pulse    out  one-cycle rising-edge strobe
// ---------------------------------------------------------------------------
module shaft_pulse_sync (
   input  logic clk,
   input  logic rst,
   input  logic shaftIn,
   output logic pulse
);

   logic meta;
   logic sync;
   logic syncDly;

   // NOTE: non-blocking assignments so each flop samples the previous stage's
   // value from before the edge; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta    <= 1'b0;
         sync    <= 1'b0;
         syncDly <= 1'b0;
      end else begin
         meta    <= shaftIn;
         sync    <= meta;
         syncDly <= sync;
      end
   end

   assign pulse = sync & ~syncDly;

endmodule

// File: rtl/junction_turn_sequencer.sv
// ---------------------------------------------------------------------------
// junction_turn_sequencer
//   Runs one junction manoeuvre (straight, left, right or U-turn) on the drive
//   H-bridge. Started by a one-cycle jctReq, it waits for a tone direction (or
//   times out to straight), lets the motors settle, then drives until both
//   wheels have produced their target number of shaft pulses. A collision
//   pauses the drive; a gap in shaft pulses longer than the stall window is a
//   sticky fault. Completion is signalled by a one-cycle done.
//
//   Ports:
//     clk, rst               clock, synchronous active-high reset
//     jctReq                 start pulse (honoured only in IDLE)
//     tdEn, tdDir            tone-detect valid and direction
//     colDetect              collision present
//     pwmFull, pwmVeer       80% / 40% PWM waveforms
//     shaftPulseL/R          asynchronous wheel encoder lines
//     hbEnA, hbEnB           H-bridge enables (left, right wheel)
//     hbIn1..hbIn4           H-bridge direction inputs
//     busy                   manoeuvre in progress
//     done                   one-cycle completion pulse
//     dirTaken               direction of the current or last manoeuvre
//     toneMiss               last manoeuvre defaulted on tone timeout
//     fault                  stall fault, held until rst
// ---------------------------------------------------------------------------
module junction_turn_sequencer
   import junction_pkg::*;
#(
   parameter int CLK_FREQ            = 50_000_000,
   parameter int SETTLE_CYCLES       = CLK_FREQ / 10,
   parameter int TONE_TIMEOUT_CYCLES = CLK_FREQ * 2,
   parameter int STALL_CYCLES        = CLK_FREQ / 2,
   parameter int STRAIGHT_PULSES     = 12,
   parameter int TURN_PULSES         = 20,
   parameter int UTURN_PULSES        = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       jctReq,
   input  logic       tdEn,
   input  logic [1:0] tdDir,
   input  logic       colDetect,
   input  logic       pwmFull,
   input  logic       pwmVeer,
   input  logic       shaftPulseL,
   input  logic       shaftPulseR,
   output logic       hbEnA,
   output logic       hbEnB,
   output logic       hbIn1,
   output logic       hbIn2,
   output logic       hbIn3,
   output logic       hbIn4,
   output logic       busy,
   output logic       done,
   output logic [1:0] dirTaken,
   output logic       toneMiss,
   output logic       fault
);

   // One timer serves both the tone wait and the settle dwell, so it is
   // sized for the longer of the two.
   localparam int PHASE_MAX = (TONE_TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                              TONE_TIMEOUT_CYCLES : SETTLE_CYCLES;
   localparam int PHASE_W   = timerWidth(PHASE_MAX);
   localparam int STALL_W   = timerWidth(STALL_CYCLES);

   localparam logic [PHASE_W-1:0] TONE_LAST   = PHASE_W'(TONE_TIMEOUT_CYCLES - 1);
   localparam logic [PHASE_W-1:0] SETTLE_LAST = PHASE_W'(SETTLE_CYCLES - 1);
   localparam logic [STALL_W-1:0] STALL_LAST  = STALL_W'(STALL_CYCLES - 1);

   localparam logic [PULSE_CNT_W-1:0] STRAIGHT_TGT = PULSE_CNT_W'(STRAIGHT_PULSES);
   localparam logic [PULSE_CNT_W-1:0] TURN_TGT     = PULSE_CNT_W'(TURN_PULSES);
   localparam logic [PULSE_CNT_W-1:0] UTURN_TGT    = PULSE_CNT_W'(UTURN_PULSES);
   localparam logic [PULSE_CNT_W-1:0] CNT_MAX      = '1;

   jctState_t              state;
   logic [PHASE_W-1:0]     phaseTmr;
   logic [STALL_W-1:0]     stallTmr;
   logic [PULSE_CNT_W-1:0] cntL;
   logic [PULSE_CNT_W-1:0] cntR;

   logic                   pulseL;
   logic                   pulseR;

   logic                   counting;
   logic [PULSE_CNT_W-1:0] cntLNext;
   logic [PULSE_CNT_W-1:0] cntRNext;
   logic [PULSE_CNT_W-1:0] target;
   logic                   pwmSel;
   logic                   wheelDoneL;
   logic                   wheelDoneR;
   logic                   anyPulse;
   logic [3:0]             execIn;
   logic                   execEnA;
   logic                   execEnB;

   shaft_pulse_sync uSyncL (
      .clk     (clk),
      .rst     (rst),
      .shaftIn (shaftPulseL),
      .pulse   (pulseL)
   );

   shaft_pulse_sync uSyncR (
      .clk     (clk),
      .rst     (rst),
      .shaftIn (shaftPulseR),
      .pulse   (pulseR)
   );

   // Next pulse counts and the drive outputs they imply. Counts run in
   // EXECUTE and keep running in PAUSE (the wheels coast), and sit at zero in
   // every other state so SETTLE hands EXECUTE a clean start. Wheel
   // completion is judged on the next counts so an enable drops on the very
   // edge that registers a wheel's final pulse.
   // NOTE: every signal gets a default first so no path through this block
   // leaves one unassigned and infers a latch.
   always_comb begin
      counting = (state == EXECUTE) || (state == PAUSE);

      cntLNext = cntL;
      cntRNext = cntR;
      if (!counting) begin
         cntLNext = '0;
         cntRNext = '0;
      end else begin
         if (pulseL && (cntL != CNT_MAX)) cntLNext = cntL + PULSE_CNT_W'(1);
         if (pulseR && (cntR != CNT_MAX)) cntRNext = cntR + PULSE_CNT_W'(1);
      end

      target = TURN_TGT;
      unique case (jctDir_t'(dirTaken))
         STRAIGHT: target = STRAIGHT_TGT;
         LEFT:     target = TURN_TGT;
         RIGHT:    target = TURN_TGT;
         BACK:     target = UTURN_TGT;
         default:  target = TURN_TGT;
      endcase

      // Straight-through runs at the gentler veer duty; spins use full duty.
      pwmSel     = (jctDir_t'(dirTaken) == STRAIGHT) ? pwmVeer : pwmFull;
      wheelDoneL = (cntLNext >= target);
      wheelDoneR = (cntRNext >= target);
      anyPulse   = pulseL | pulseR;
      execIn     = inPattern(jctDir_t'(dirTaken));
      execEnA    = pwmSel & ~wheelDoneL;
      execEnB    = pwmSel & ~wheelDoneR;
   end

   // Sequencer. All outputs are registered and describe the state being
   // entered, so done/busy/fault change on the same edge as the state.
   // NOTE: the reset is synchronous; there is no memory array here, so every
   // register, counters included, takes an explicit reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state                      <= IDLE;
         phaseTmr                   <= '0;
         stallTmr                   <= '0;
         cntL                       <= '0;
         cntR                       <= '0;
         hbEnA                      <= 1'b0;
         hbEnB                      <= 1'b0;
         {hbIn1, hbIn2, hbIn3, hbIn4} <= 4'b0000;
         busy                       <= 1'b0;
         done                       <= 1'b0;
         dirTaken                   <= STRAIGHT;
         toneMiss                   <= 1'b0;
         fault                      <= 1'b0;
      end else begin
         cntL <= cntLNext;
         cntR <= cntRNext;
         done <= 1'b0;

         case (state)
            IDLE: begin
               hbEnA                      <= 1'b0;
               hbEnB                      <= 1'b0;
               {hbIn1, hbIn2, hbIn3, hbIn4} <= 4'b0000;
               if (jctReq) begin
                  state    <= WAIT_TONE;
                  busy     <= 1'b1;
                  toneMiss <= 1'b0;
                  phaseTmr <= '0;
               end
            end

            WAIT_TONE: begin
               // A tone arriving on the timeout cycle still counts as heard.
               if (tdEn) begin
                  dirTaken <= tdDir;
                  state    <= SETTLE;
                  phaseTmr <= '0;
               end else if (phaseTmr == TONE_LAST) begin
                  dirTaken <= STRAIGHT;
                  toneMiss <= 1'b1;
                  state    <= SETTLE;
                  phaseTmr <= '0;
               end else begin
                  phaseTmr <= phaseTmr + PHASE_W'(1);
               end
            end

            SETTLE: begin
               stallTmr <= '0;
               if (phaseTmr == SETTLE_LAST) begin
                  state                      <= EXECUTE;
                  hbEnA                      <= execEnA;
                  hbEnB                      <= execEnB;
                  {hbIn1, hbIn2, hbIn3, hbIn4} <= execIn;
               end else begin
                  phaseTmr <= phaseTmr + PHASE_W'(1);
               end
            end

            EXECUTE: begin
               if (wheelDoneL && wheelDoneR) begin
                  state                      <= DONE;
                  hbEnA                      <= 1'b0;
                  hbEnB                      <= 1'b0;
                  {hbIn1, hbIn2, hbIn3, hbIn4} <= 4'b0000;
                  busy                       <= 1'b0;
                  done                       <= 1'b1;
               end else if (colDetect) begin
                  // Cut the drive but keep the direction lines so the
                  // bridge resumes exactly where it left off.
                  state <= PAUSE;
                  hbEnA <= 1'b0;
                  hbEnB <= 1'b0;
               end else if (!anyPulse && (stallTmr == STALL_LAST)) begin
                  state                      <= FAULT;
                  hbEnA                      <= 1'b0;
                  hbEnB                      <= 1'b0;
                  {hbIn1, hbIn2, hbIn3, hbIn4} <= 4'b0000;
                  busy                       <= 1'b0;
                  fault                      <= 1'b1;
               end else begin
                  stallTmr                   <= anyPulse ? '0 : stallTmr + STALL_W'(1);
                  hbEnA                      <= execEnA;
                  hbEnB                      <= execEnB;
                  {hbIn1, hbIn2, hbIn3, hbIn4} <= execIn;
               end
            end

            PAUSE: begin
               // Stall timer is frozen: a stationary robot behind an
               // obstacle is not a stalled wheel.
               if (!colDetect) begin
                  state                      <= EXECUTE;
                  hbEnA                      <= execEnA;
                  hbEnB                      <= execEnB;
                  {hbIn1, hbIn2, hbIn3, hbIn4} <= execIn;
               end
            end

            DONE: begin
               state <= IDLE;
            end

            FAULT: begin
               // Terminal until rst; outputs were parked on entry.
               state <= FAULT;
            end

            default: begin
               state                      <= IDLE;
               hbEnA                      <= 1'b0;
               hbEnB                      <= 1'b0;
               {hbIn1, hbIn2, hbIn3, hbIn4} <= 4'b0000;
               busy                       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/junction_turn_sequencer.md
Name: junction_turn_sequencer

Overview:
Sequences the drive H-bridge through one junction manoeuvre: straight, left, right, or back (U-turn).
- The drive state machine hands control to this block when it enters its junction state, by pulsing jctReq.
- The block waits for a valid tone direction, then drives the motors for a shaft-pulse-measured distance.
- It handles collision pauses and wheel stalls, then returns control with a one-cycle done.
- The top level muxes this block's H-bridge outputs onto the pins while busy=1.

Parameters:
- CLK_FREQ, 50_000_000, clock frequency in Hz.
- SETTLE_CYCLES, CLK_FREQ/10, motors-off dwell before executing (100 ms).
- TONE_TIMEOUT_CYCLES, CLK_FREQ*2, maximum wait for tdEn before defaulting to straight.
- STALL_CYCLES, CLK_FREQ/2, maximum gap between shaft pulses while executing before fault.
- STRAIGHT_PULSES, 12, per-wheel pulse target for straight-through.
- TURN_PULSES, 20, per-wheel pulse target for a 90-degree spin.
- UTURN_PULSES, 40, per-wheel pulse target for a 180-degree spin.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- jctReq  in  1  one-cycle start pulse from the drive state machine.
- tdEn  in  1  tone-detect valid.
- tdDir  in  2  tone direction: 00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 BACK.
- colDetect  in  1  collision present.
- pwmFull  in  1  80% PWM waveform.
- pwmVeer  in  1  40% PWM waveform.
- shaftPulseL  in  1  left encoder, asynchronous.
- shaftPulseR  in  1  right encoder, asynchronous.
- hbEnA, hbEnB  out  1 each  H-bridge enables.
- hbIn1..hbIn4  out  1 each  H-bridge direction inputs.
- busy  out  1  high from accepted jctReq until done.
- done  out  1  one-cycle completion pulse.
- dirTaken  out  2  direction latched for the current or last manoeuvre.
- toneMiss  out  1  last manoeuvre defaulted on tone timeout.
- fault  out  1  stall fault, sticky until rst.

Behaviour:
- Reset: state IDLE. All hb* = 0, busy = done = fault = toneMiss = 0, dirTaken = 00. Counters and timers cleared.
- Shaft inputs: each goes through a 2-FF synchronizer plus rising-edge detect. A pulse is counted 3 cycles after the input rises.
- Pulse counters are 8-bit and saturate at 255.
- IDLE:
  - Outputs all 0.
  - jctReq -> WAIT_TONE, busy = 1, toneMiss cleared.
  - jctReq is ignored in every other state.
- WAIT_TONE:
  - Motors off.
  - tdEn = 1 -> latch tdDir into dirTaken, go to SETTLE.
  - Timer reaching TONE_TIMEOUT_CYCLES-1 -> dirTaken = 00, toneMiss = 1, go to SETTLE.
  - If tdEn is sampled in the same cycle as the timeout, tdEn wins.
- SETTLE:
  - Motors off for SETTLE_CYCLES.
  - Pulse counters and stall timer cleared, then go to EXECUTE.
- EXECUTE: outputs are registered, with one-cycle lag on the PWM inputs.
  - STRAIGHT: In1..4 = 0110, EnA = EnB = pwmVeer, target STRAIGHT_PULSES.
  - LEFT: In1..4 = 1010, En = pwmFull, target TURN_PULSES.
  - RIGHT: In1..4 = 0101, En = pwmFull, target TURN_PULSES.
  - BACK: In1..4 = 0101, En = pwmFull, target UTURN_PULSES.
  - Each wheel's enable is forced to 0 once that wheel's count >= target.
  - Both counts >= target -> DONE.
  - colDetect = 1 -> PAUSE. Completion takes priority over collision in the same cycle.
  - Stall timer resets on any counted pulse (either wheel). Reaching STALL_CYCLES-1 -> FAULT.
- PAUSE:
  - Enables = 0, In lines held.
  - Counters held; pulses still counted (coast).
  - Stall timer held.
  - colDetect = 0 -> EXECUTE.
- DONE:
  - Motors off, done = 1 for exactly one cycle, busy = 0 in the same cycle.
  - Next state IDLE.
- FAULT:
  - All hb* = 0, fault = 1, busy = 0, done never asserted.
  - Only rst exits.
- rst in any state returns to the reset values on the next edge; a manoeuvre in progress is abandoned.
- Timers are ceil(log2(max cycles)) bits wide and count up from 0.

Decomposition:
- Package junction_pkg holds:
  - state encoding: IDLE, WAIT_TONE, SETTLE, EXECUTE, PAUSE, DONE, FAULT.
  - direction codes: STRAIGHT, LEFT, RIGHT, BACK.
  - 4-bit H-bridge In patterns: FWD 0110, SPIN_L 1010, SPIN_R 0101.
- Sub-module shaft_pulse_sync: 2-FF synchronizer plus rising-edge one-shot, instantiated once per wheel.

Test Plan:
Test parameters: SETTLE = 4, TONE_TIMEOUT = 50, STALL = 30, STRAIGHT = 3, TURN = 5, UTURN = 10.
1. Left turn:
   - Stimulus: jctReq, tdEn with tdDir = 01 at cycle 5, 5 pulses per wheel.
   - Required: In = 1010, En follows pwmFull; each En drops after its 5th pulse; done = 1 for one cycle; busy falls; dirTaken = 01.
2. Tone timeout:
   - Stimulus: jctReq, no tdEn for 50 cycles.
   - Required: toneMiss = 1, dirTaken = 00, In = 0110 with pwmVeer; done after 3 pulses per wheel.
3. Collision pause:
   - Stimulus: BACK manoeuvre, colDetect asserted after 4 pulses for 100 cycles, then released.
   - Required: En = 0 throughout the pause with no fault; resumes; done after 10 total pulses per wheel.
4. Stall:
   - Stimulus: RIGHT manoeuvre, 2 pulses then none.
   - Required: fault = 1 exactly 30 cycles after the last counted pulse; hb* all 0; subsequent jctReq ignored until rst.
5. Reset mid-EXECUTE:
   - Stimulus: rst asserted during a turn.
   - Required: next cycle all outputs 0 and state IDLE; a fresh jctReq runs a full manoeuvre normally.
6. Asymmetric wheels:
   - Stimulus: LEFT manoeuvre, left wheel reaches 5 pulses first.
   - Required: hbEnA = 0 while hbEnB still PWMs; done only after the right wheel's 5th pulse.
